pgr_baud_gen: RTL

PGR_BAUD_GEN -- requirements
Module: pgr_baud_gen

---
 rtl/pgr_baud_pkg.sv | 13 +
 rtl/pgr_frac_acc.sv | 29 ++
 rtl/pgr_baud_gen.sv | 74 +++++++
 3 files changed

// File: rtl/pgr_baud_pkg.sv
// Shared constants and helpers for the programmable baud/oversample generator.
package pgr_baud_pkg;

  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned FRAC_W_DEF = 4;
  localparam int unsigned OVS_DEF    = 16;

  // Width of the phase index; at least one bit even when OVS is 1.
  function automatic int unsigned phase_width(input int unsigned ovs);
    return (ovs > 1) ? $clog2(ovs) : 1;
  endfunction

endpackage

// File: rtl/pgr_frac_acc.sv
// Fractional period accumulator: adds the fraction once per period and
// requests a one-cycle stretch of the following period on carry out.
module pgr_frac_acc #(
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac,
  output logic              ext
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum_c;

  assign sum_c = {1'b0, acc} + {1'b0, frac};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      ext <= 1'b0;
    end else if (step) begin
      acc <= sum_c[FRAC_W-1:0];
      ext <= sum_c[FRAC_W];
    end
  end

endmodule

// File: rtl/pgr_baud_gen.sv
// Fractional-N baud generator: os_tick every div+1(+1 on fraction carry)
// cycles, bit_tick once per OVS os_ticks, with phase restart on sync_clr.
module pgr_baud_gen
  import pgr_baud_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF,
  parameter int unsigned OVS    = OVS_DEF,
  localparam int unsigned PH_W  = phase_width(OVS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync_clr,
  input  logic [CNT_W-1:0]  clk_div,
  input  logic [FRAC_W-1:0] clk_frac,
  output logic              os_tick,
  output logic              bit_tick,
  output logic [PH_W-1:0]   phase
);

  localparam int unsigned CW1 = CNT_W + 1;

  logic [CNT_W-1:0]  div_q;
  logic [FRAC_W-1:0] frac_q;
  logic [CW1-1:0]    cnt;
  logic              ext;
  logic              term_c;
  logic              phase_last_c;
  logic              acc_step_c;

  // One bit wider than div_q so a maximal divider plus stretch cannot wrap.
  assign term_c       = (cnt == ({1'b0, div_q} + CW1'(ext)));
  assign phase_last_c = (phase == PH_W'(OVS - 1));
  assign acc_step_c   = en && term_c && !sync_clr;

  pgr_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (sync_clr),
    .step (acc_step_c),
    .frac (frac_q),
    .ext  (ext)
  );

  always_ff @(posedge clk) begin
    if (rst || sync_clr) begin
      cnt      <= '0;
      phase    <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      div_q    <= clk_div;
      frac_q   <= clk_frac;
    end else if (!en) begin
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end else if (term_c) begin
      // Period boundary: tick, advance phase, pick up the next period setting.
      cnt      <= '0;
      os_tick  <= 1'b1;
      bit_tick <= phase_last_c;
      phase    <= phase_last_c ? '0 : phase + PH_W'(1);
      div_q    <= clk_div;
      frac_q   <= clk_frac;
    end else begin
      cnt      <= cnt + CW1'(1);
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end
  end

endmodule
